// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM encodings, requester IDs, default widths.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned STARVE_W   = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GRANT_IF = 2'd1;
  localparam logic [1:0] ST_GRANT_DM = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  localparam logic ARB_IF = 1'b0;
  localparam logic ARB_DM = 1'b1;

  // Saturating increment used by the IF starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                     input logic [STARVE_W-1:0] lim);
    return (cnt >= lim) ? cnt : cnt + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_wdog.sv
// Grant watchdog: counts cycles while run is high, flags the last allowed cycle.
// Only instantiated when ARB_WDOG_EN is defined.
module mem_port_arbiter_wdog #(
  parameter int unsigned CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc_c
);

  localparam int unsigned CNT_W = $clog2(CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign tc_c = run && (cnt == CNT_W'(CYC - 1));

  // Held at zero outside a grant so every grant starts from a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (!tc_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the data port.
// Optional grant watchdog enabled by defining ARB_WDOG_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned WDOG_CYC   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX out of range 1..15");
  end
  if (WDOG_CYC < 1) begin : g_bad_wdog
    $error("mem_port_arbiter: WDOG_CYC must be at least 1");
  end

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [1:0]          state, state_d;
  logic                owner, owner_d;
  logic [STARVE_W-1:0] starve_cnt, starve_d;
  logic                mem_req_d, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic                if_ack_d, dm_ack_d, err_d;
  logic [DATA_W-1:0]   if_rdata_d, dm_rdata_d;
  logic                wdog_tc_c;

`ifdef ARB_WDOG_EN
  logic grant_c;
  assign grant_c = (state == ST_GRANT_IF) || (state == ST_GRANT_DM);

  mem_port_arbiter_wdog #(
    .CYC (WDOG_CYC)
  ) u_arb_wdog (
    .clk  (clk),
    .rst  (rst),
    .run  (grant_c),
    .tc_c (wdog_tc_c)
  );
`else
  assign wdog_tc_c = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    starve_d    = starve_cnt;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;

    case (state)
      ST_IDLE: begin
        if (dm_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
          state_d     = ST_GRANT_DM;
          owner_d     = ARB_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            starve_d = starve_inc(starve_cnt, STARVE_LIM);
          end
        end else if (if_req) begin
          state_d     = ST_GRANT_IF;
          owner_d     = ARB_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      ST_GRANT_IF, ST_GRANT_DM: begin
        // A real completion beats a watchdog expiry in the same cycle.
        if (mem_ack) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          if (owner == ARB_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            if (!mem_we) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end else if (wdog_tc_c) begin
          state_d   = ST_RESP;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (owner == ARB_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= ARB_IF;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      err        <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state      <= state_d;
      owner      <= owner_d;
      starve_cnt <= starve_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      if_ack     <= if_ack_d;
      dm_ack     <= dm_ack_d;
      err        <= err_d;
      if_rdata   <= if_rdata_d;
      dm_rdata   <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; covers ARB_WDOG_EN when the macro is defined.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          err;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4),
    .WDOG_CYC   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_ack    (dm_ack),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic exp_dm [6];
  int   ack_seen;

  initial begin
    exp_dm = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_dm_ack", 32'(dm_ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_if_rdata", 32'(if_rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;

    // IF only, L=2
    if_req = 1'b1; if_addr = 16'h0010;
    tick();
    chk("t1_c1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_c1_mem_we", 32'(mem_we), 32'd0);
    chk("t1_c1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("t1_c1_if_ack", 32'(if_ack), 32'd0);
    tick();
    chk("t1_c2_mem_req", 32'(mem_req), 32'd1);
    tick();
    chk("t1_c3_mem_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = '0; if_req = 1'b0;
    chk("t1_c4_if_ack", 32'(if_ack), 32'd1);
    chk("t1_c4_if_rdata", 32'(if_rdata), 32'hBEEF);
    chk("t1_c4_mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("t1_c5_if_ack", 32'(if_ack), 32'd0);

    // Store, L=1
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
    tick();
    chk("t2_c1_mem_req", 32'(mem_req), 32'd1);
    chk("t2_c1_mem_we", 32'(mem_we), 32'd1);
    chk("t2_c1_mem_addr", 32'(mem_addr), 32'h0200);
    chk("t2_c1_mem_wdata", 32'(mem_wdata), 32'h1234);
    tick();
    chk("t2_c2_mem_we", 32'(mem_we), 32'd1);
    chk("t2_c2_mem_addr", 32'(mem_addr), 32'h0200);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    chk("t2_c3_dm_ack", 32'(dm_ack), 32'd1);
    chk("t2_c3_if_ack", 32'(if_ack), 32'd0);
    chk("t2_c3_dm_rdata", 32'(dm_rdata), 32'h0000);
    chk("t2_c3_mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("t2_c4_dm_ack", 32'(dm_ack), 32'd0);

    // Contention: DM x4, then IF forced, then DM
    if_req = 1'b1; if_addr = 16'h0040;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0300;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t3_g%0d_addr", i), 32'(mem_addr), exp_dm[i] ? 32'h0300 : 32'h0040);
      mem_ack = 1'b1; mem_rdata = 16'hA000 + 16'(i);
      tick();
      mem_ack = 1'b0;
      chk($sformatf("t3_g%0d_dm_ack", i), 32'(dm_ack), 32'(exp_dm[i]));
      chk($sformatf("t3_g%0d_if_ack", i), 32'(if_ack), 32'(!exp_dm[i]));
      if (exp_dm[i]) chk($sformatf("t3_g%0d_dm_rdata", i), 32'(dm_rdata), 32'hA000 + 32'(i));
      else           chk($sformatf("t3_g%0d_if_rdata", i), 32'(if_rdata), 32'hA000 + 32'(i));
      if (i == 5) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      tick();
    end

    // Reset one cycle after mem_req rises on a DM grant
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400;
    tick();
    chk("t4_c1_mem_req", 32'(mem_req), 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("t4_async_mem_req", 32'(mem_req), 32'd0);
    chk("t4_async_dm_ack", 32'(dm_ack), 32'd0);
    tick();
    rst = 1'b0; dm_req = 1'b0;
    tick();
    chk("t4_post_dm_ack", 32'(dm_ack), 32'd0);
    chk("t4_post_mem_req", 32'(mem_req), 32'd0);
    if_req = 1'b1; if_addr = 16'h0444;
    tick();
    chk("t4_idle_grant_req", 32'(mem_req), 32'd1);
    chk("t4_idle_grant_addr", 32'(mem_addr), 32'h0444);
    mem_ack = 1'b1; mem_rdata = 16'h4444;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    chk("t4_if_ack", 32'(if_ack), 32'd1);
    tick();

    // Stray mem_ack in IDLE, then back-to-back IF requests
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    chk("t5_stray_mem_req", 32'(mem_req), 32'd0);
    chk("t5_stray_if_ack", 32'(if_ack), 32'd0);
    chk("t5_stray_dm_ack", 32'(dm_ack), 32'd0);
    chk("t5_stray_if_rdata", 32'(if_rdata), 32'h4444);
    tick();
    chk("t5_stray_if_ack2", 32'(if_ack), 32'd0);
    if_req = 1'b1; if_addr = 16'h0050;
    tick();
    chk("t5_a_addr", 32'(mem_addr), 32'h0050);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0; if_addr = 16'h0060;
    chk("t5_a_if_ack", 32'(if_ack), 32'd1);
    chk("t5_a_if_rdata", 32'(if_rdata), 32'h1111);
    tick();
    chk("t5_gap1_if_ack", 32'(if_ack), 32'd0);
    chk("t5_gap1_mem_req", 32'(mem_req), 32'd0);
    tick();
    chk("t5_b_addr", 32'(mem_addr), 32'h0060);
    chk("t5_gap2_if_ack", 32'(if_ack), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    chk("t5_b_if_ack", 32'(if_ack), 32'd1);
    chk("t5_b_if_rdata", 32'(if_rdata), 32'h2222);
    tick();

    // Memory never answers an IF grant
    if_req = 1'b1; if_addr = 16'h0070; mem_rdata = 16'h7777;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t6_c%0d_mem_req", k), 32'(mem_req), 32'd1);
      chk($sformatf("t6_c%0d_if_ack", k), 32'(if_ack), 32'd0);
    end
    tick();
`ifdef ARB_WDOG_EN
    if_req = 1'b0;
    chk("t6_c9_if_ack", 32'(if_ack), 32'd1);
    chk("t6_c9_err", 32'(err), 32'd1);
    chk("t6_c9_if_rdata", 32'(if_rdata), 32'h0000);
    chk("t6_c9_mem_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t6_late_if_ack", 32'(if_ack), 32'd0);
    chk("t6_late_err", 32'(err), 32'd0);
    tick();
    chk("t6_late_if_rdata", 32'(if_rdata), 32'h0000);
    chk("t6_late_mem_req", 32'(mem_req), 32'd0);
`else
    ack_seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (if_ack || err) ack_seen++;
      tick();
    end
    chk("t6_no_ack_100", 32'(ack_seen), 32'd0);
    chk("t6_still_req", 32'(mem_req), 32'd1);
    chk("t6_err", 32'(err), 32'd0);
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0; if_req = 1'b0;
    chk("t6_final_if_ack", 32'(if_ack), 32'd1);
    chk("t6_final_if_rdata", 32'(if_rdata), 32'h7777);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
